// File: rtl/imem_loader.sv
// Byte-stream program loader: receives a framed program (sync, word count, big-endian words, XOR checksum)
// and writes it into instruction memory while holding the processor in reset until the frame checks good.
module imem_loader #(
    parameter int          ADDR_WIDTH = 12,
    parameter int unsigned MAX_WORDS  = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wren_imem,
    output logic [ADDR_WIDTH-1:0] address_imem,
    output logic [31:0]           data_imem,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    state_t                  state;
    logic [7:0]              cnt_hi;
    logic [15:0]             words_left;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [1:0]              byte_idx;
    logic [31:0]             word_p0;
    logic [7:0]              csum;
    logic [15:0]             n_word;
    logic [31:0]             word_full;

    assign in_ready  = 1'b1;
    assign n_word    = {cnt_hi, in_data};
    assign word_full = {word_p0[23:0], in_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt_hi       <= '0;
            words_left   <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            word_p0      <= '0;
            csum         <= '0;
            wren_imem    <= 1'b0;
            address_imem <= '0;
            data_imem    <= '0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            wren_imem <= 1'b0;
            if (in_valid) begin
                case (state)
                    IDLE: begin
                        if (in_data == SYNC) begin
                            state <= CNT_HI;
                            busy  <= 1'b1;
                        end
                    end
                    CNT_HI: begin
                        cnt_hi <= in_data;
                        state  <= CNT_LO;
                    end
                    CNT_LO: begin
                        word_idx   <= '0;
                        byte_idx   <= '0;
                        csum       <= '0;
                        words_left <= n_word;
                        if ({16'd0, n_word} > MAX_WORDS) begin
                            state <= ERR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else if (n_word == 16'd0) begin
                            state <= CHK;
                        end else begin
                            state <= DATA;
                        end
                    end
                    // Assembly stage (word_p0) feeds a separate write stage so full-rate bytes never drop a write
                    DATA: begin
                        word_p0  <= word_full;
                        csum     <= csum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            wren_imem    <= 1'b1;
                            address_imem <= word_idx;
                            data_imem    <= word_full;
                            word_idx     <= word_idx + ADDR_WIDTH'(1);
                            words_left   <= words_left - 16'd1;
                            if (words_left == 16'd1)
                                state <= CHK;
                        end
                    end
                    CHK: begin
                        busy <= 1'b0;
                        if (in_data == csum) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (in_data == SYNC) begin
                            state     <= CNT_HI;
                            done      <= 1'b0;
                            cpu_reset <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    ERR: begin
                        if (in_data == SYNC) begin
                            state <= CNT_HI;
                            error <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are driven byte by byte and imem writes are collected
// from the write port for comparison against hand-computed words and addresses.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wren_imem;
    logic [11:0] address_imem;
    logic [31:0] data_imem;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] wa[$];
    logic [31:0] wd[$];

    logic [7:0] good_frame[12] = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56,
                                   8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};

    imem_loader #(.ADDR_WIDTH(12), .MAX_WORDS(4096)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .wren_imem    (wren_imem),
        .address_imem (address_imem),
        .data_imem    (data_imem),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wren_imem === 1'b1) begin
            wa.push_back(address_imem);
            wd.push_back(data_imem);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic d, input logic e,
                                input logic cr, input logic b);
        check({tag, "_done"}, {31'd0, done}, {31'd0, d});
        check({tag, "_error"}, {31'd0, error}, {31'd0, e});
        check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, cr});
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_wren"}, {31'd0, wren_imem}, 32'd0);
        check({tag, "_addr"}, {20'd0, address_imem}, 32'd0);
        check({tag, "_data"}, data_imem, 32'd0);
        check_status(tag, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_two_writes(input string tag);
        check({tag, "_nwrites"}, wa.size(), 32'd2);
        if (wa.size() == 2) begin
            check({tag, "_addr0"}, {20'd0, wa[0]}, 32'd0);
            check({tag, "_data0"}, wd[0], 32'h12345678);
            check({tag, "_addr1"}, {20'd0, wa[1]}, 32'd1);
            check({tag, "_data1"}, wd[1], 32'hDEADBEEF);
        end
    endtask

    initial begin
        reset    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        #12;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);
        check_reset_outputs("por_released");

        // Garbage in IDLE is discarded
        send(8'h00); send(8'hFF); send(8'h5A);
        check_status("garbage", 1'b0, 1'b0, 1'b1, 1'b0);
        check("garbage_nwrites", wa.size(), 32'd0);

        // Normal frame with random gaps between bytes
        for (int i = 0; i < 12; i++) begin
            send(good_frame[i]);
            if (i < 11) idle($urandom_range(1, 3));
        end
        check_status("gaps", 1'b1, 1'b0, 1'b0, 1'b0);
        check_two_writes("gaps");
        wa.delete(); wd.delete();

        // Full-rate normal frame with cycle-exact write timing
        send(8'hA5);
        check_status("rerun_sync", 1'b0, 1'b0, 1'b1, 1'b1);
        send(8'h00); send(8'h02);
        send(8'h12); send(8'h34); send(8'h56);
        check("fr_wren_pre", {31'd0, wren_imem}, 32'd0);
        send(8'h78);
        check("fr_wren0", {31'd0, wren_imem}, 32'd1);
        check("fr_addr0", {20'd0, address_imem}, 32'd0);
        check("fr_data0", data_imem, 32'h12345678);
        send(8'hDE);
        check("fr_wren_gap", {31'd0, wren_imem}, 32'd0);
        check("fr_data_hold", data_imem, 32'h12345678);
        send(8'hAD); send(8'hBE); send(8'hEF);
        check("fr_wren1", {31'd0, wren_imem}, 32'd1);
        check("fr_addr1", {20'd0, address_imem}, 32'd1);
        check("fr_data1", data_imem, 32'hDEADBEEF);
        send(8'h2A);
        check("fr_wren_end", {31'd0, wren_imem}, 32'd0);
        check_status("fr_end", 1'b1, 1'b0, 1'b0, 1'b0);
        check_two_writes("fr");
        wa.delete(); wd.delete();

        // Empty frame
        send(8'hA5); send(8'h00); send(8'h00);
        check_status("empty_chk", 1'b0, 1'b0, 1'b1, 1'b1);
        send(8'h00);
        check_status("empty_end", 1'b1, 1'b0, 1'b0, 1'b0);
        check("empty_nwrites", wa.size(), 32'd0);

        // Bad checksum keeps the writes but flags error
        for (int i = 0; i < 11; i++) send(good_frame[i]);
        send(8'h2B);
        check_status("badck", 1'b0, 1'b1, 1'b1, 1'b0);
        check_two_writes("badck");
        wa.delete(); wd.delete();
        for (int i = 0; i < 12; i++) send(good_frame[i]);
        check_status("recover", 1'b1, 1'b0, 1'b0, 1'b0);
        check_two_writes("recover");
        wa.delete(); wd.delete();

        // Overflow: N = 4097
        send(8'hA5); send(8'h10); send(8'h01);
        check_status("ovf", 1'b0, 1'b1, 1'b1, 1'b0);
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        check_status("ovf_ignore", 1'b0, 1'b1, 1'b1, 1'b0);
        check("ovf_nwrites", wa.size(), 32'd0);

        // N = 4096 is the largest accepted count
        send(8'hA5);
        check_status("max_sync", 1'b0, 1'b0, 1'b1, 1'b1);
        send(8'h10); send(8'h00);
        check_status("max_accept", 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of a frame, after its 6th byte
        reset = 1'b0;
        #1;
        reset = 1'b1;
        idle(1);
        for (int i = 0; i < 6; i++) send(good_frame[i]);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #2;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);
        for (int i = 0; i < 12; i++) send(good_frame[i]);
        check_status("after_reset", 1'b1, 1'b0, 1'b0, 1'b0);
        check_two_writes("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
